// File: rtl/udp_port_dispatch.sv
// udp_port_dispatch: routes whole UDP payload packets to one of N_SINK sinks
// using a runtime-programmable destination-port table. Unmatched packets are
// either discarded or sent to the last sink, depending on DROP_UNMATCHED.
// Optional per-sink/drop/length-error counters under UDP_DISPATCH_STATS_EN.

// One table entry: holds {enable, port} and compares against the live port.
module udp_port_dispatch_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [15:0] wr_port,
  input  logic        wr_en,
  input  logic [15:0] dest,
  output logic        hit
);
  logic [15:0] port_q;
  logic        en_q;

  // Entry storage; cleared to disabled/port 0 on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_q <= '0;
      en_q   <= 1'b0;
    end else if (wr) begin
      port_q <= wr_port;
      en_q   <= wr_en;
    end
  end

  assign hit = en_q && (port_q == dest);
endmodule

module udp_port_dispatch #(
  parameter int N_SINK         = 4,
  parameter bit DROP_UNMATCHED = 1'b1,
  localparam int SEL_W         = (N_SINK > 1) ? $clog2(N_SINK) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic [15:0]       s_dest_port,
  input  logic [15:0]       s_length,
  output logic [7:0]        m_tdata,
  output logic              m_tlast,
  output logic [N_SINK-1:0] m_tvalid,
  input  logic [N_SINK-1:0] m_tready,
  input  logic              cfg_wr,
  input  logic [SEL_W-1:0]  cfg_idx,
  input  logic [15:0]       cfg_port,
  input  logic              cfg_en,
  output logic              busy_out,
  output logic              len_err_out
`ifdef UDP_DISPATCH_STATS_EN
  ,
  output logic [N_SINK*16-1:0] pkt_cnt_out,
  output logic [15:0]          drop_cnt_out,
  output logic [15:0]          len_err_cnt_out
`endif
);
  typedef enum logic [1:0] {IDLE, LOOKUP, FWD, DROP} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [15:0]        cnt;
  logic [N_SINK-1:0]  hit;
  logic               hit_any;
  logic [SEL_W-1:0]   hit_idx;
  logic               fire;
  logic               len_bad;

  // Table entries; indices >= N_SINK never match any instance, so those writes vanish.
  for (genvar g = 0; g < N_SINK; g++) begin : g_ent
    udp_port_dispatch_entry u_ent (
      .clk     (clk),
      .reset   (reset),
      .wr      (cfg_wr && (cfg_idx == SEL_W'(g))),
      .wr_port (cfg_port),
      .wr_en   (cfg_en),
      .dest    (s_dest_port),
      .hit     (hit[g])
    );
  end

  // Lowest-index match wins: scan high to low so the last assignment is the lowest.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = N_SINK - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign fire    = s_tvalid && s_tready;
  // Compare in 17 bits so a saturated counter cannot wrap into a false match.
  assign len_bad = (s_length != 16'd0) && (({1'b0, cnt} + 17'd1) != {1'b0, s_length});

  // Combinational pass-through to the selected sink; drop state swallows beats.
  assign s_tready = (state == FWD) ? m_tready[sel] : (state == DROP);
  assign m_tdata  = s_tdata;
  assign m_tlast  = s_tlast;

  // Only the latched sink sees valid, and only while forwarding.
  always_comb begin
    m_tvalid = '0;
    if (state == FWD) m_tvalid[sel] = s_tvalid;
  end

  // Packet FSM: latch the route once per packet, count beats, flag length errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      busy_out    <= 1'b0;
      len_err_out <= 1'b0;
    end else begin
      len_err_out <= 1'b0;
      case (state)
        IDLE: begin
          if (s_tvalid) begin
            state    <= LOOKUP;
            busy_out <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            sel   <= hit_idx;
            state <= FWD;
          end else if (DROP_UNMATCHED) begin
            state <= DROP;
          end else begin
            sel   <= SEL_W'(N_SINK - 1);
            state <= FWD;
          end
        end
        FWD, DROP: begin
          if (fire) begin
            if (s_tlast) begin
              state       <= IDLE;
              busy_out    <= 1'b0;
              cnt         <= '0;
              len_err_out <= len_bad;
            end else if (cnt != 16'hFFFF) begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UDP_DISPATCH_STATS_EN
  // Wrapping event counters, all bumped on the tlast beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_out     <= '0;
      drop_cnt_out    <= '0;
      len_err_cnt_out <= '0;
    end else if (fire && s_tlast) begin
      if (state == FWD)
        pkt_cnt_out[{sel, 4'b0000} +: 16] <= pkt_cnt_out[{sel, 4'b0000} +: 16] + 16'd1;
      if (state == DROP) drop_cnt_out <= drop_cnt_out + 16'd1;
      if (len_bad) len_err_cnt_out <= len_err_cnt_out + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_udp_port_dispatch.sv
// Scoreboard bench for udp_port_dispatch: driver pushes expected sink beats and
// length-error flags, a negedge monitor pops and compares.
module tb_udp_port_dispatch;
  localparam int N_SINK = 4;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic [15:0]       s_dest_port = '0;
  logic [15:0]       s_length = '0;
  logic [7:0]        m_tdata;
  logic              m_tlast;
  logic [N_SINK-1:0] m_tvalid;
  logic [N_SINK-1:0] m_tready;
  logic              cfg_wr = 1'b0;
  logic [SEL_W-1:0]  cfg_idx = '0;
  logic [15:0]       cfg_port = '0;
  logic              cfg_en = 1'b0;
  logic              busy_out;
  logic              len_err_out;
`ifdef UDP_DISPATCH_STATS_EN
  logic [N_SINK*16-1:0] pkt_cnt_out;
  logic [15:0]          drop_cnt_out;
  logic [15:0]          len_err_cnt_out;
`endif

  udp_port_dispatch #(.N_SINK(N_SINK), .DROP_UNMATCHED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .s_dest_port(s_dest_port), .s_length(s_length),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_port(cfg_port), .cfg_en(cfg_en),
    .busy_out(busy_out), .len_err_out(len_err_out)
`ifdef UDP_DISPATCH_STATS_EN
    , .pkt_cnt_out(pkt_cnt_out), .drop_cnt_out(drop_cnt_out), .len_err_cnt_out(len_err_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: port table, expected-beat and length-flag queues, event counts.
  logic [15:0] mport [N_SINK];
  bit          men   [N_SINK];
  typedef struct { int sink; logic [7:0] data; bit last; } beat_t;
  beat_t exp_q[$];
  bit    le_q[$];
  int    m_drop = 0, m_lerr = 0;
  int    m_pkt [N_SINK];

  function automatic int route(input logic [15:0] d);
    for (int i = 0; i < N_SINK; i++)
      if (men[i] && mport[i] == d) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_SINK; i++) begin
      mport[i] = '0; men[i] = 1'b0; m_pkt[i] = 0;
    end
    m_drop = 0; m_lerr = 0;
  endtask

  // Sink readiness: random per cycle in mode 1, else driven by rdy_force.
  int                rdy_mode = 0;
  logic [N_SINK-1:0] rdy_force = '1;
  logic [N_SINK-1:0] rnd_rdy = '1;
  assign m_tready = (rdy_mode == 1) ? rnd_rdy : rdy_force;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N_SINK; i++) rnd_rdy[i] = ($urandom_range(3) != 0);
  end

  // Monitor: compare every sink transfer and the length-error pulse.
  bit le_pend = 0, le_exp = 0;
  always @(negedge clk) begin
    if (reset) begin
      le_pend = 0;
    end else begin
      if (m_tvalid != '0) chk("onehot_tvalid", $countones(m_tvalid), 1);
      for (int i = 0; i < N_SINK; i++) begin
        if (m_tvalid[i] && m_tready[i]) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: sink %0d data %0h, none expected", i, m_tdata);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            chk("sink", i, b.sink);
            chk("data", m_tdata, b.data);
            chk("last", m_tlast, b.last);
          end
        end
      end
      chk("len_err", len_err_out, le_pend ? le_exp : 1'b0);
      le_pend = 0;
      if (s_tvalid && s_tready && s_tlast) begin
        le_pend = 1;
        if (le_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tlast: got tlast transfer expected none");
          le_exp = 0;
        end else le_exp = le_q.pop_front();
      end
    end
  end

  task automatic beat(input logic [7:0] d, input bit last, output int w);
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last; w = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      w++;
      if (w > 500) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] p, input bit en);
    cfg_wr = 1'b1; cfg_idx = SEL_W'(idx); cfg_port = p; cfg_en = en;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    if (idx < N_SINK) begin mport[idx] = p; men[idx] = en; end
  endtask

  // Send one packet; stall_at/wr_at < 0 disables the stall / mid-packet entry-0 disable.
  task automatic send_pkt(input logic [15:0] dest, input int n, input logic [15:0] len,
                          input bit fixed, input int stall_at, input int wr_at,
                          output int w0, output int wrest);
    int sink, w;
    logic [7:0] d;
    bit last;
    sink = route(dest);
    s_dest_port = dest; s_length = len;
    if (sink < 0) m_drop++; else m_pkt[sink]++;
    if (len != 0 && int'(len) != n) m_lerr++;
    w0 = 0; wrest = 0;
    for (int i = 0; i < n; i++) begin
      d = fixed ? 8'(8'hAA + i * 8'h11) : 8'($urandom);
      last = (i == n - 1);
      if (sink >= 0) exp_q.push_back('{sink, d, last});
      if (last) le_q.push_back(len != 0 && int'(len) != n);
      if (i == wr_at) begin
        cfg_wr = 1'b1; cfg_idx = '0; cfg_port = mport[0]; cfg_en = 1'b0;
        men[0] = 1'b0;
      end
      if (i == stall_at && sink >= 0) begin
        rdy_force[sink] = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        repeat (5) begin
          @(negedge clk);
          chk("stall_tready", s_tready, 1'b0);
          @(posedge clk); #1;
          cfg_wr = 1'b0;
        end
        rdy_force[sink] = 1'b1;
      end
      beat(d, last, w);
      cfg_wr = 1'b0;
      if (i == 0) w0 = w; else wrest += w;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, wr, n;
    logic [15:0] dest, len;
    logic [15:0] pset [4];
    pset[0] = 16'h1F90; pset[1] = 16'h0400; pset[2] = 16'h0035; pset[3] = 16'h1234;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_tvalid", m_tvalid, '0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_len_err", len_err_out, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic forward with 2-cycle first-byte latency
    cfg_write(0, 16'h1F90, 1'b1);
    send_pkt(16'h1F90, 4, 16'd4, 1'b1, -1, -1, w0, wr);
    chk("lat_first", w0, 2);
    chk("lat_rest", wr, 0);

    // Duplicate entries: lowest index wins
    cfg_write(1, 16'h0400, 1'b1);
    cfg_write(2, 16'h0400, 1'b1);
    send_pkt(16'h0400, 5, 16'd5, 1'b0, -1, -1, w0, wr);

    // Unmatched: dropped, always ready after lookup, back to idle
    send_pkt(16'h1234, 4, 16'd4, 1'b0, -1, -1, w0, wr);
    chk("drop_first_wait", w0, 2);
    chk("drop_rest_wait", wr, 0);
    @(negedge clk);
    chk("drop_idle_busy", busy_out, 1'b0);
    @(posedge clk); #1;

    // Sink backpressure for 5 cycles mid-packet
    rdy_mode = 2;
    send_pkt(16'h1F90, 6, 16'd6, 1'b0, 2, -1, w0, wr);

    // Length mismatch pulses; unknown length never does
    send_pkt(16'h1F90, 5, 16'd6, 1'b0, -1, -1, w0, wr);
    send_pkt(16'h1F90, 5, 16'd0, 1'b0, -1, -1, w0, wr);
    send_pkt(16'h0400, 1, 16'd1, 1'b0, -1, -1, w0, wr);

    // Disable entry 0 during an entry-0 packet: only the next packet is dropped
    send_pkt(16'h1F90, 4, 16'd4, 1'b0, -1, 1, w0, wr);
    send_pkt(16'h1F90, 3, 16'd3, 1'b0, -1, -1, w0, wr);
    chk("disabled_drop_wait", w0 + wr, 2);

    // Randomized traffic
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0)
        cfg_write($urandom_range(N_SINK - 1), pset[$urandom_range(3)], 1'($urandom_range(1)));
      dest = ($urandom_range(3) != 0) ? pset[$urandom_range(3)] : 16'($urandom);
      n = $urandom_range(8, 1);
      case ($urandom_range(3))
        0: len = 16'd0;
        1: len = 16'(n + $urandom_range(2, 1));
        default: len = 16'(n);
      endcase
      send_pkt(dest, n, len, 1'b0, -1, -1, w0, wr);
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    // Reset mid-packet
    rdy_mode = 0; rdy_force = '1;
    repeat (2) @(posedge clk);
    #1;
    cfg_write(0, 16'h0035, 1'b1);
    s_dest_port = 16'h0035; s_length = 16'd8;
    exp_q.push_back('{0, 8'h11, 1'b0});
    exp_q.push_back('{0, 8'h22, 1'b0});
    beat(8'h11, 1'b0, w0);
    beat(8'h22, 1'b0, w0);
    s_tdata = 8'h33; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", m_tvalid, '0);
    chk("midrst_busy", busy_out, 1'b0);
    @(posedge clk); #1;
    s_tvalid = 1'b0; reset = 1'b0;
    model_clear();
    send_pkt(16'h0035, 3, 16'd3, 1'b0, -1, -1, w0, wr);
    chk("post_rst_drop_wait", w0 + wr, 2);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("le_q_empty", le_q.size(), 0);
`ifdef UDP_DISPATCH_STATS_EN
    chk("drop_cnt", drop_cnt_out, 16'(m_drop));
    chk("len_err_cnt", len_err_cnt_out, 16'(m_lerr));
    for (int i = 0; i < N_SINK; i++) chk("pkt_cnt", pkt_cnt_out[i*16 +: 16], 16'(m_pkt[i]));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
